pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard controller for the five-stage, 19-bit-instruction, 8-bit-register pipeline. It sequences PC and pipeline-register enables, bubbles and flushes around stage 2 (decode, register file, stack, controller). It resolves four hazard classes: load-use, flag-use by conditional branches, taken redirects, and stack returns. It also drives the EX operand forwarding selects and keeps a saturating stall/flush performance counter.

## Interface

- `LOAD_STALLS`, default 1: bubble cycles inserted per load-use hazard; legal range 1..7.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs1`, `id_rs2` in 3 each: stage-2 read addresses (`instruction[10:8]` and the selected R2 address).
- `id_use_rs1`, `id_use_rs2` in 1 each: the stage-2 instruction really reads that operand.
- `id_cond_br` in 1: stage-2 instruction is a Z/C-conditional branch.
- `id_redirect` in 1: stage-2 instruction redirects the PC (pcInputSel ≠ sequential), excluding return.
- `id_ret` in 1: stage-2 instruction pops the stack (return).
- `ex_dest` in 3, `ex_regWrite` in 1, `ex_LDM` in 1, `ex_flagWr` in 1: stage-3 destination, register-write enable, load flag, and Cenb|Zenb.
- `ex_rs1`, `ex_rs2` in 3 each: stage-3 operand addresses.
- `mem_dest` in 3, `mem_regWrite` in 1, `mem_LDM` in 1: stage-4 destination, write enable, load flag.
- `wb_dest` in 3, `wb_regWrite` in 1: stage-5 destination and write enable.
- `pcEnb` out 1: PC load enable.
- `ifIdEnb` out 1: IF/ID register enable.
- `ifIdFlush` out 1: IF/ID loads a NOP.
- `idExBubble` out 1: ID/EX loads a NOP (all control signals 0).
- `fwdA`, `fwdB` out 2 each: EX operand select. 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB write data, 11 = unused.
- `stallCount` out 16: saturating count of cycles with `pcEnb`=0 or `ifIdFlush`=1.

## Operation

- **States:** RUN, LDSTALL, FLAGSTALL, RETWAIT. The FSM has a 3-bit down-counter `cnt`.
- **Hazard terms** (combinational on inputs):
  - `ldHaz = ex_LDM & ex_regWrite & ((id_use_rs1 & id_rs1==ex_dest) | (id_use_rs2 & id_rs2==ex_dest))`
  - `flHaz = id_cond_br & ex_flagWr`
- **RUN, priority ldHaz > flHaz > id_ret > id_redirect:**
  - **ldHaz:**
    - `pcEnb`=0, `ifIdEnb`=0, `idExBubble`=1.
    - If `LOAD_STALLS`>1, load `cnt`=`LOAD_STALLS`-1 and go to LDSTALL; otherwise stay in RUN.
  - **flHaz:** `pcEnb`=0, `ifIdEnb`=0, `idExBubble`=1; go to FLAGSTALL.
  - **id_ret:** `pcEnb`=0 (the stack output is registered and not yet valid), `ifIdFlush`=1; go to RETWAIT.
  - **id_redirect:** `pcEnb`=1, `ifIdFlush`=1; stay in RUN.
  - **none:** `pcEnb`=1, `ifIdEnb`=1, no flush or bubble.
- **LDSTALL:**
  - Hold PC and IF/ID, bubble ID/EX.
  - Decrement `cnt`; go to RUN when `cnt`==1 on entry to the cycle.
- **FLAGSTALL:**
  - One cycle: hold PC and IF/ID, bubble ID/EX.
  - Then return to RUN; the flags are now committed, so the branch re-evaluates.
- **RETWAIT:**
  - One cycle: `pcEnb`=1 (PC loads the popped address), `ifIdFlush`=1, `idExBubble`=1 (the return is not re-issued).
  - Then go to RUN.
- **Forwarding** (per operand, shown for A; B is identical using `ex_rs2`):
  - If `mem_regWrite` & !`mem_LDM` & `ex_rs1`==`mem_dest`, then 01.
  - Else if `wb_regWrite` & `ex_rs1`==`wb_dest`, then 10.
  - Else 00.
  - EX/MEM has priority over MEM/WB. A load sitting in MEM is never a forwarding source.
- **`ifIdFlush` and `ifIdEnb`:** a flush overrides `ifIdEnb`. The two are never both active with `pcEnb`=0 except in the return case.
- **`stallCount`:** increments on every cycle where `pcEnb`=0 or `ifIdFlush`=1, and saturates at 16'hFFFF.

## Timing

- **Reset values:**
  - State RUN, `cnt`=0, `stallCount`=0.
  - Outputs `pcEnb`=1, `ifIdEnb`=1, `ifIdFlush`=0, `idExBubble`=0, `fwdA`=`fwdB`=00.
- **Reset mid-stall:** abandons the stall immediately, with no residual bubble after `rst` deasserts.
- **Output decode:** all enables, flushes and forwards are combinational from the current state and inputs, valid in the same cycle. The state and `stallCount` update on the rising edge of `clk`.
- **Hazard penalties:**
  - Load-use: exactly `LOAD_STALLS` bubble cycles.
  - Flag-use: 1 bubble cycle.
  - Redirect: 1 flushed fetch.
  - Return: 2 cycles (hold, then load and flush).
- **Hazards arising inside a stall state** (stall, FLAGSTALL or RETWAIT cycle): ignored until RUN.
- **Re-evaluation on return to RUN:** in the first RUN cycle, the held stage-2 instruction is re-evaluated. A conditional branch that needed a load is therefore handled as ldHaz and then flHaz, sequentially.
- **Simultaneous id_ret and id_redirect:** id_ret wins.

## Test plan

- **Load-use:** load R3 in EX, add reading R3 in ID, `LOAD_STALLS`=1 → one cycle with `pcEnb`=0 and `idExBubble`=1. Next cycle RUN, and in EX `fwdA`=10 (source is WB).
- **Longer load-use:** same stimulus with `LOAD_STALLS`=3 → exactly 3 bubble cycles, `stallCount` advances by 3.
- **Flag-use:** ADD with `ex_flagWr`=1, conditional branch in ID → 1 bubble cycle. The next cycle with `id_redirect`=1 gives `ifIdFlush`=1 and `pcEnb`=1.
- **Return:** `id_ret`=1 → cycle 1 `pcEnb`=0 and `ifIdFlush`=1; cycle 2 `pcEnb`=1, `ifIdFlush`=1, `idExBubble`=1; cycle 3 normal.
- **Forwarding priority:** `mem_dest`=`wb_dest`=`ex_rs2`=5, both writes set, `mem_LDM`=0 → `fwdB`=01. With `mem_LDM`=1 → `fwdB`=10.
- **Async reset mid-stall:** assert `rst` asynchronously in the middle of LDSTALL with `stallCount`=7 → outputs go to reset values before the next edge, and `stallCount`=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: PC/IF-ID enables, bubbles, flushes,
// EX operand forwarding selects and a saturating stall/flush cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALLS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs1_i,
  input  logic [2:0]  id_rs2_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic        id_cond_br_i,
  input  logic        id_redirect_i,
  input  logic        id_ret_i,
  input  logic [2:0]  ex_dest_i,
  input  logic        ex_regWrite_i,
  input  logic        ex_LDM_i,
  input  logic        ex_flagWr_i,
  input  logic [2:0]  ex_rs1_i,
  input  logic [2:0]  ex_rs2_i,
  input  logic [2:0]  mem_dest_i,
  input  logic        mem_regWrite_i,
  input  logic        mem_LDM_i,
  input  logic [2:0]  wb_dest_i,
  input  logic        wb_regWrite_i,
  output logic        pcEnb_o,
  output logic        ifIdEnb_o,
  output logic        ifIdFlush_o,
  output logic        idExBubble_o,
  output logic [1:0]  fwdA_o,
  output logic [1:0]  fwdB_o,
  output logic [15:0] stallCount_o
);

  typedef enum logic [1:0] {StRun, StLdStall, StFlagStall, StRetWait} state_e;

  localparam logic [2:0] LdReload = 3'(LOAD_STALLS - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        ld_haz, fl_haz;

  assign ld_haz = ex_LDM_i & ex_regWrite_i &
                  ((id_use_rs1_i & (id_rs1_i == ex_dest_i)) |
                   (id_use_rs2_i & (id_rs2_i == ex_dest_i)));
  assign fl_haz = id_cond_br_i & ex_flagWr_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pcEnb_o      = 1'b1;
    ifIdEnb_o    = 1'b1;
    ifIdFlush_o  = 1'b0;
    idExBubble_o = 1'b0;
    case (state_q)
      StRun: begin
        if (ld_haz) begin
          pcEnb_o      = 1'b0;
          ifIdEnb_o    = 1'b0;
          idExBubble_o = 1'b1;
          if (LOAD_STALLS > 1) begin
            cnt_d   = LdReload;
            state_d = StLdStall;
          end
        end else if (fl_haz) begin
          pcEnb_o      = 1'b0;
          ifIdEnb_o    = 1'b0;
          idExBubble_o = 1'b1;
          state_d      = StFlagStall;
        end else if (id_ret_i) begin
          // Stack output is registered: hold the PC one cycle before loading it.
          pcEnb_o     = 1'b0;
          ifIdFlush_o = 1'b1;
          state_d     = StRetWait;
        end else if (id_redirect_i) begin
          ifIdFlush_o = 1'b1;
        end
      end
      StLdStall: begin
        pcEnb_o      = 1'b0;
        ifIdEnb_o    = 1'b0;
        idExBubble_o = 1'b1;
        cnt_d        = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = StRun;
      end
      StFlagStall: begin
        pcEnb_o      = 1'b0;
        ifIdEnb_o    = 1'b0;
        idExBubble_o = 1'b1;
        state_d      = StRun;
      end
      StRetWait: begin
        ifIdFlush_o  = 1'b1;
        idExBubble_o = 1'b1;
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  function automatic logic [1:0] fwd_sel(input logic [2:0] rs);
    if (mem_regWrite_i && !mem_LDM_i && (rs == mem_dest_i)) return 2'b01;
    if (wb_regWrite_i && (rs == wb_dest_i)) return 2'b10;
    return 2'b00;
  endfunction

  assign fwdA_o = fwd_sel(ex_rs1_i);
  assign fwdB_o = fwd_sel(ex_rs2_i);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((!pcEnb_o || ifIdFlush_o) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign stallCount_o = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      cnt_q       <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
